// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
//   Words written through wr_en/wr_data are queued in a DEPTH-entry FIFO and
//   serialised on uart_tx as start bit, DATA_BITS data bits (LSB first),
//   optional even-parity bit, then STOP_BITS stop bits. Frames queued behind
//   one another go out back-to-back with no idle gap.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit after
//   the data bits. Without it there is no parity state and no parity logic.
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   wr_data   word to enqueue
//   wr_en     enqueue strobe, accepted only when full==0
//   full      FIFO holds DEPTH words (registered)
//   empty     FIFO holds no words (registered)
//   busy      shifter not idle, or FIFO not empty
//   overflow  sticky, set by wr_en while full
//   uart_tx   serial line, idle high (registered)
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 wr_en,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 overflow,
    output logic                 uart_tx
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BaudReload = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LastData   = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LastStop   = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count, count_d;
    logic                 push, pop, last_tick;
    logic [DATA_BITS-1:0] head;

    state_e               state;
    logic [BW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    assign head      = mem[rd_ptr];
    assign push      = wr_en && !full;
    assign last_tick = (baud_cnt == '0);
    assign busy      = (state != StIdle) || !empty;

    // Pop either from idle, or at the final tick of the last stop bit so the
    // next start bit follows with no gap.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == StIdle) begin
                pop = 1'b1;
            end else if (state == StStop && last_tick && bit_cnt == LastStop) begin
                pop = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + 1'b1;
        end else if (!push && pop) begin
            count_d = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shift    <= head;
`ifdef UART_TX_PARITY_EN
                        parity   <= ^head;
`endif
                        uart_tx  <= 1'b0;
                        baud_cnt <= BaudReload;
                        bit_cnt  <= '0;
                        state    <= StStart;
                    end
                end
                StStart: begin
                    if (last_tick) begin
                        uart_tx  <= shift[0];
                        baud_cnt <= BaudReload;
                        bit_cnt  <= '0;
                        state    <= StData;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                StData: begin
                    if (last_tick) begin
                        baud_cnt <= BaudReload;
                        if (bit_cnt == LastData) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            uart_tx <= parity;
                            state   <= StParity;
`else
                            uart_tx <= 1'b1;
                            state   <= StStop;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift >> 1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (last_tick) begin
                        uart_tx  <= 1'b1;
                        baud_cnt <= BaudReload;
                        bit_cnt  <= '0;
                        state    <= StStop;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (last_tick) begin
                        baud_cnt <= BaudReload;
                        if (bit_cnt == LastStop) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                shift   <= head;
`ifdef UART_TX_PARITY_EN
                                parity  <= ^head;
`endif
                                uart_tx <= 1'b0;
                                state   <= StStart;
                            end else begin
                                state   <= StIdle;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int C  = 4;
    localparam int D  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P  = 1;
`else
    localparam int P  = 0;
`endif
    localparam int FL = (1 + 8 + P + 1) * C;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       full, empty, busy, overflow, uart_tx;

    logic       rst2 = 1'b0;
    logic       wr_en2 = 1'b0;
    logic [6:0] wr_data2 = '0;
    logic       full2, empty2, busy2, overflow2, uart_tx2;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of accepted words and queue of future line levels.
    logic [7:0] m_q[$];
    logic       m_line[$];
    logic       m_tx = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_ovf = 1'b0;
    logic [4:0] vexp, vgot;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full), .empty(empty),
        .busy(busy), .overflow(overflow), .uart_tx(uart_tx)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(2), .DEPTH(D)) dut2 (
        .clk(clk), .rst(rst2), .wr_data(wr_data2), .wr_en(wr_en2), .full(full2),
        .empty(empty2), .busy(busy2), .overflow(overflow2), .uart_tx(uart_tx2)
    );

    // Drive one clock of stimulus and advance the model; sample point is #1 after the edge.
    task automatic step(input logic we, input logic [7:0] d, input logic r);
        int sz;
        logic took;
        logic [7:0] w;
        wr_en = we;
        wr_data = d;
        rst = r;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_line.delete();
            m_ovf = 1'b0;
            m_tx = 1'b1;
            m_busy = 1'b0;
        end else begin
            sz = m_q.size();
            if (m_line.size() == 0 && sz > 0) begin
                w = m_q.pop_front();
                for (int b = 0; b < C; b++) m_line.push_back(1'b0);
                for (int i = 0; i < 8; i++)
                    for (int b = 0; b < C; b++) m_line.push_back(w[i]);
                if (P == 1)
                    for (int b = 0; b < C; b++) m_line.push_back(^w);
                for (int b = 0; b < C; b++) m_line.push_back(1'b1);
            end
            if (we) begin
                if (sz < D) m_q.push_back(d);
                else m_ovf = 1'b1;
            end
            took = 1'b0;
            m_tx = 1'b1;
            if (m_line.size() > 0) begin
                m_tx = m_line.pop_front();
                took = 1'b1;
            end
            m_busy = took || (m_q.size() > 0);
        end
        vexp = {m_tx, m_busy, m_q.size() == D, m_q.size() == 0, m_ovf};
        #1;
        vgot = {uart_tx, busy, full, empty, overflow};
    endtask

    task automatic test_reset();
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (vgot !== 5'b1_0_0_1_0) begin
            errors++;
            $display("FAIL reset {tx,busy,full,empty,ovf} got %b exp %b", vgot, 5'b1_0_0_1_0);
        end
    endtask

    task automatic test_single();
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h55, 1'b0);
        for (int i = 1; i <= FL + 4; i++) begin
            step(1'b0, 8'h00, 1'b0);
            checks++;
            if (vgot !== vexp) begin
                errors++;
                $display("FAIL single cyc %0d got %b exp %b", i, vgot, vexp);
            end
            if (i == FL || i == FL + 1) begin
                checks++;
                if (busy !== (i == FL)) begin
                    errors++;
                    $display("FAIL single_busy_end cyc %0d got %b exp %b", i, busy, i == FL);
                end
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] words[5];
        words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, words[i], 1'b0);
            checks++;
            if (vgot !== vexp || full !== (i == 4)) begin
                errors++;
                $display("FAIL burst_full wr %0d got %b exp %b full %b", i, vgot, vexp, full);
            end
        end
        step(1'b1, 8'hF6, 1'b0);
        checks++;
        if (overflow !== 1'b1 || vgot !== vexp) begin
            errors++;
            $display("FAIL burst_overflow got %b exp %b", vgot, vexp);
        end
        for (int i = 0; i < 5 * FL + 8; i++) begin
            step(1'b0, 8'h00, 1'b0);
            checks++;
            if (vgot !== vexp) begin
                errors++;
                $display("FAIL burst cyc %0d got %b exp %b", i, vgot, vexp);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (uart_tx !== 1'b1 || empty !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid tx %b empty %b ovf %b exp 1 1 0", uart_tx, empty, overflow);
        end
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < FL + 4; i++) begin
            step(1'b0, 8'h00, 1'b0);
            checks++;
            if (vgot !== vexp) begin
                errors++;
                $display("FAIL reset_mid_frame cyc %0d got %b exp %b", i, vgot, vexp);
            end
        end
    endtask

    task automatic test_full_pop();
        int guard;
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        guard = 0;
        while (m_line.size() != 0 && guard < 200) begin
            step(1'b0, 8'h00, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 200 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_setup guard %0d full %b exp 1", guard, full);
        end
        step(1'b1, 8'h99, 1'b0);
        checks++;
        if (overflow !== 1'b1 || full !== 1'b0 || uart_tx !== 1'b0 || vgot !== vexp) begin
            errors++;
            $display("FAIL full_pop got %b exp %b (ovf=1 full=0 tx=0)", vgot, vexp);
        end
        for (int i = 0; i < 4 * FL + 4; i++) begin
            step(1'b0, 8'h00, 1'b0);
            checks++;
            if (vgot !== vexp) begin
                errors++;
                $display("FAIL full_pop_drain cyc %0d got %b exp %b", i, vgot, vexp);
            end
        end
    endtask

    task automatic test_parity();
`ifdef UART_TX_PARITY_EN
        logic [7:0] words[2];
        words = '{8'h07, 8'h03};
        step(1'b0, 8'h00, 1'b1);
        for (int w = 0; w < 2; w++) begin
            step(1'b1, words[w], 1'b0);
            for (int i = 1; i <= FL + 2; i++) begin
                step(1'b0, 8'h00, 1'b0);
                checks++;
                if (vgot !== vexp) begin
                    errors++;
                    $display("FAIL parity word %0d cyc %0d got %b exp %b", w, i, vgot, vexp);
                end
                if (i == 37) begin
                    checks++;
                    if (uart_tx !== (w == 0)) begin
                        errors++;
                        $display("FAIL parity_bit word %0d got %b exp %b", w, uart_tx, w == 0);
                    end
                end
                if (i == 44 || i == 45) begin
                    checks++;
                    if (busy !== (i == 44)) begin
                        errors++;
                        $display("FAIL parity_len cyc %0d busy %b exp %b", i, busy, i == 44);
                    end
                end
            end
        end
`endif
    endtask

    task automatic test_stop2();
        logic exp_tx;
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        wr_en2 = 1'b1;
        wr_data2 = 7'h7F;
        @(posedge clk);
        #1;
        wr_en2 = 1'b0;
        for (int i = 1; i <= 42; i++) begin
            @(posedge clk);
            #1;
            exp_tx = (i > 4);
            checks++;
            if (uart_tx2 !== exp_tx || busy2 !== (i <= 40)) begin
                errors++;
                $display("FAIL stop2 cyc %0d tx %b busy %b exp %b %b", i, uart_tx2, busy2,
                         exp_tx, i <= 40);
            end
        end
    endtask

    task automatic test_random();
        logic we, r;
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            we = ($urandom_range(0, 9) < 2);
            r = ($urandom_range(0, 499) == 0);
            step(we, 8'($urandom), r);
            checks++;
            if (vgot !== vexp) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b", i, vgot, vexp);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_reset_mid();
        test_full_pop();
        test_parity();
        test_stop2();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
